// File: rtl/sram_serial_ctrl.sv
// rtl/sram_serial_ctrl.sv - serial-load SRAM front end with command FSM and word array
//
// Purpose: assembles DATA_WIDTH-bit words from a serial bit stream and runs
// write/read commands against an internal 2**ADDR_WIDTH word array, with
// configurable write and sense latency and an auto-incrementing pointer.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears FSM, datapath and array)
//   serial_in   serial data bit
//   shift       shift serial_in into the word register (IDLE only)
//   w_en        write command strobe
//   r_en        read command strobe
//   addr        command address when auto_inc=0
//   auto_inc    1: use the internal pointer as the command address
//   busy        write or read in progress
//   word_ready  a full word has been shifted in since the last write
//   data_out    last read word, held until the next read completes
//   data_valid  one-cycle pulse when data_out updates
//   err         one-cycle pulse on a rejected command
module sram_serial_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int MSB_FIRST    = 1,
    parameter int WRITE_CYCLES = 1,
    parameter int SENSE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  shift,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  auto_inc,
    output logic                  busy,
    output logic                  word_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  err
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int MAX_LAT = (WRITE_CYCLES > SENSE_CYCLES) ? WRITE_CYCLES : SENSE_CYCLES;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [LAT_W-1:0] WR_LAST  = LAT_W'(WRITE_CYCLES - 1);
    localparam logic [LAT_W-1:0] RD_LAST  = LAT_W'(SENSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [DATA_WIDTH-1:0]   sr;
    logic [CNT_W-1:0]        bit_cnt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [LAT_W-1:0]        lat_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   ea;

    logic                    accept_wr;
    logic                    accept_rd;
    logic                    reject;
    logic                    do_shift;
    logic                    commit;
    logic                    sense_done;

    assign ea         = auto_inc ? ptr : addr;
    assign word_ready = (bit_cnt == CNT_FULL);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        reject     = 1'b0;
        do_shift   = 1'b0;
        commit     = 1'b0;
        sense_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (w_en && r_en) begin
                    reject = 1'b1;
                end else if (w_en && !word_ready) begin
                    reject = 1'b1;
                end else if (w_en) begin
                    accept_wr  = 1'b1;
                    state_next = ST_WR;
                end else if (r_en) begin
                    accept_rd  = 1'b1;
                    state_next = ST_RD;
                end
                // Any write strobe (accepted or not) wins over a same-cycle shift.
                do_shift = shift && !w_en;
            end
            ST_WR: begin
                reject = w_en || r_en;
                if (lat_cnt == WR_LAST) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                reject = w_en || r_en;
                if (lat_cnt == RD_LAST) begin
                    sense_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            bit_cnt    <= '0;
            ptr        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            data_valid <= 1'b0;
            err        <= reject;

            // Latency counter runs from 0 while busy and restarts on every new operation.
            if (accept_wr || accept_rd || commit || sense_done) begin
                lat_cnt <= '0;
            end else if (busy) begin
                lat_cnt <= lat_cnt + 1'b1;
            end

            if (accept_wr || accept_rd) begin
                addr_q <= ea;
                ptr    <= ea + 1'b1;
            end

            if (accept_wr) begin
                wdata_q <= sr;
                bit_cnt <= '0;
            end

            if (do_shift) begin
                if (MSB_FIRST != 0) begin
                    sr <= {sr[DATA_WIDTH-2:0], serial_in};
                end else begin
                    sr <= {serial_in, sr[DATA_WIDTH-1:1]};
                end
                if (bit_cnt != CNT_FULL) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (commit) begin
                mem[addr_q] <= wdata_q;
            end

            if (sense_done) begin
                data_out   <= mem[addr_q];
                data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// tb/tb_sram_serial_ctrl.sv - self-checking bench for sram_serial_ctrl
module tb_sram_serial_ctrl;

    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int WRC   = 1;
    localparam int SNC   = 2;

    logic          clk;
    logic          rst;
    logic          serial_in;
    logic          shift;
    logic          w_en;
    logic          r_en;
    logic [AW-1:0] addr;
    logic          auto_inc;

    logic          busy;
    logic          word_ready;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          err;

    logic          b_busy;
    logic          b_word_ready;
    logic [W-1:0]  b_data_out;
    logic          b_data_valid;
    logic          b_err;

    int checks = 0;
    int errors = 0;

    sram_serial_ctrl #(
        .DATA_WIDTH(W), .ADDR_WIDTH(AW), .MSB_FIRST(1),
        .WRITE_CYCLES(WRC), .SENSE_CYCLES(SNC)
    ) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift),
        .w_en(w_en), .r_en(r_en), .addr(addr), .auto_inc(auto_inc),
        .busy(busy), .word_ready(word_ready), .data_out(data_out),
        .data_valid(data_valid), .err(err)
    );

    sram_serial_ctrl #(
        .DATA_WIDTH(W), .ADDR_WIDTH(AW), .MSB_FIRST(0),
        .WRITE_CYCLES(WRC), .SENSE_CYCLES(SNC)
    ) dut_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift),
        .w_en(w_en), .r_en(r_en), .addr(addr), .auto_inc(auto_inc),
        .busy(b_busy), .word_ready(b_word_ready), .data_out(b_data_out),
        .data_valid(b_data_valid), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the MSB_FIRST=1 instance, state as seen after the latest edge.
    int m_mem [DEPTH];
    int m_ptr   = 0;
    int m_left  = 0;
    bit m_is_wr = 0;
    int m_a     = 0;
    int m_d     = 0;
    int m_dout  = 0;
    int m_dv    = 0;
    int m_err   = 0;
    bit m_q [$];

    function automatic int model_word();
        int v = 0;
        for (int i = 0; i < m_q.size(); i++) begin
            v += int'(m_q[i]) * (1 << (W - 1 - i));
        end
        return v;
    endfunction

    task automatic model_step();
        int ea;
        int nv = 0;
        int ne = 0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_ptr = 0; m_left = 0; m_dout = 0; m_q.delete();
        end else if (m_left > 0) begin
            if (w_en || r_en) ne = 1;
            m_left--;
            if (m_left == 0) begin
                if (m_is_wr) m_mem[m_a] = m_d;
                else begin
                    m_dout = m_mem[m_a];
                    nv = 1;
                end
            end
        end else begin
            ea = auto_inc ? m_ptr : int'(addr);
            if (w_en && r_en) ne = 1;
            else if (w_en && m_q.size() != W) ne = 1;
            else if (w_en) begin
                m_is_wr = 1; m_a = ea; m_d = model_word();
                m_q.delete();
                m_ptr = (ea + 1) % DEPTH;
                m_left = WRC;
            end else begin
                if (r_en) begin
                    m_is_wr = 0; m_a = ea;
                    m_ptr = (ea + 1) % DEPTH;
                    m_left = SNC;
                end
                if (shift) begin
                    m_q.push_back(serial_in);
                    if (m_q.size() > W) void'(m_q.pop_front());
                end
            end
        end
        m_dv  = nv;
        m_err = ne;
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model with
    // the inputs the DUT will sample at the coming edge.
    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        forever begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(m_left > 0));
            check("word_ready", 32'(word_ready), 32'(m_q.size() == W));
            check("data_out", 32'(data_out), 32'(m_dout));
            check("data_valid", 32'(data_valid), 32'(m_dv));
            check("err", 32'(err), 32'(m_err));
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            serial_in = v[i];
            shift = 1'b1;
            tick();
            shift = 1'b0;
        end
    endtask

    task automatic do_write(input int a, input logic ai);
        int n = 0;
        addr = AW'(a); auto_inc = ai; w_en = 1'b1;
        tick();
        w_en = 1'b0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL write_timeout: busy still 1, required 0");
        end
    endtask

    task automatic do_read(input int a, input logic ai, output logic [W-1:0] d);
        int n = 0;
        addr = AW'(a); auto_inc = ai; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        while (!data_valid && n < 20) begin
            tick();
            n++;
        end
        if (!data_valid) begin
            errors++;
            $display("FAIL read_timeout: data_valid never 1");
        end
        d = data_out;
    endtask

    logic [W-1:0] rd;

    initial begin
        rst = 1'b1; serial_in = 1'b0; shift = 1'b0; w_en = 1'b0; r_en = 1'b0;
        addr = '0; auto_inc = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_word_ready", 32'(word_ready), 32'h0);

        // Basic write then read with sense timing
        shift_bits(32'b10100101, 8);
        check("t1_word_ready", 32'(word_ready), 32'h1);
        do_write(3, 1'b0);
        addr = 4'd3; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("t1_busy_c1", 32'(busy), 32'h1);
        check("t1_dv_c1", 32'(data_valid), 32'h0);
        tick();
        check("t1_busy_c2", 32'(busy), 32'h1);
        check("t1_dv_c2", 32'(data_valid), 32'h0);
        tick();
        check("t1_dv_done", 32'(data_valid), 32'h1);
        check("t1_busy_done", 32'(busy), 32'h0);
        check("t1_data", 32'(data_out), 32'hA5);

        // Short word write rejected
        shift_bits(32'b10110, 5);
        addr = 4'd3; w_en = 1'b1;
        tick();
        w_en = 1'b0;
        check("t2_err", 32'(err), 32'h1);
        check("t2_busy", 32'(busy), 32'h0);
        check("t2_word_ready", 32'(word_ready), 32'h0);
        do_read(3, 1'b0, rd);
        check("t2_read", 32'(rd), 32'hA5);

        // Burst with pointer wrap
        shift_bits(32'h11, 8); do_write(14, 1'b0);
        shift_bits(32'h22, 8); do_write(0, 1'b1);
        shift_bits(32'h33, 8); do_write(0, 1'b1);
        do_read(14, 1'b0, rd); check("t3_r14", 32'(rd), 32'h11);
        do_read(0, 1'b1, rd);  check("t3_r15", 32'(rd), 32'h22);
        do_read(0, 1'b1, rd);  check("t3_r0", 32'(rd), 32'h33);

        // Simultaneous strobes, then command during read
        shift_bits(32'h77, 8);
        addr = 4'd5; auto_inc = 1'b0; w_en = 1'b1; r_en = 1'b1;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        check("t4_both_err", 32'(err), 32'h1);
        check("t4_both_busy", 32'(busy), 32'h0);
        check("t4_word_kept", 32'(word_ready), 32'h1);
        do_write(0, 1'b1);
        do_read(1, 1'b0, rd);
        check("t4_ptr_kept", 32'(rd), 32'h77);
        addr = 4'd1; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        tick();
        r_en = 1'b1; addr = 4'd0;
        tick();
        r_en = 1'b0;
        check("t4_busy_err", 32'(err), 32'h1);
        check("t4_dv", 32'(data_valid), 32'h1);
        check("t4_data", 32'(data_out), 32'h77);
        tick();
        check("t4_single_dv", 32'(data_valid), 32'h0);
        check("t4_idle", 32'(busy), 32'h0);

        // Reset during read
        addr = 4'd1; r_en = 1'b1;
        tick();
        r_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_dv", 32'(data_valid), 32'h0);
        check("t5_data", 32'(data_out), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_word_ready", 32'(word_ready), 32'h0);
        tick();
        check("t5_no_late_dv", 32'(data_valid), 32'h0);
        do_read(1, 1'b0, rd);  check("t5_r1", 32'(rd), 32'h00);
        do_read(15, 1'b0, rd); check("t5_r15", 32'(rd), 32'h00);

        // Bit order of both instances
        shift_bits(32'b11110000, 8);
        do_write(0, 1'b0);
        do_read(0, 1'b0, rd);
        check("t6_msb_first", 32'(rd), 32'hF0);
        check("t6_lsb_first", 32'(b_data_out), 32'h0F);

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            shift     = 1'($urandom_range(0, 1));
            serial_in = 1'($urandom_range(0, 1));
            w_en      = ($urandom_range(0, 7) == 0);
            r_en      = ($urandom_range(0, 7) == 0);
            addr      = AW'($urandom_range(0, DEPTH - 1));
            auto_inc  = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; shift = 1'b0; w_en = 1'b0; r_en = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_serial_ctrl.md
Name: sram_serial_ctrl

Overview:
Parametrised serial-load SRAM front end with an internal word array. A serial shift port assembles DATA_WIDTH-bit words. A small FSM executes write and read commands with configurable write and sense latency, an auto-incrementing address pointer for bursts, and a busy/error handshake. It replaces the fixed 1-bit-by-2-row top and is the command/data interface above the SRAM array.

Parameters:
DATA_WIDTH, 8, word width in bits (>=2)
ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH
MSB_FIRST, 1, 1: first shifted bit lands in MSB; 0: first bit lands in LSB
WRITE_CYCLES, 1, cycles from write acceptance to array commit (>=1)
SENSE_CYCLES, 2, cycles from read acceptance to data_valid (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit
shift  input  1  shift serial_in into the word register this cycle
w_en  input  1  write command (single-cycle strobe)
r_en  input  1  read command (single-cycle strobe)
addr  input  ADDR_WIDTH  command address when auto_inc=0
auto_inc  input  1  1: use internal pointer instead of addr
busy  output  1  operation in progress
word_ready  output  1  DATA_WIDTH bits accumulated since last write
data_out  output  DATA_WIDTH  last read word; holds until next read completes
data_valid  output  1  one-cycle pulse when data_out updates
err  output  1  one-cycle pulse on rejected command

Behaviour:
- Reset: rst sampled high at a rising edge clears all state.
  - State goes to IDLE; shift register, bit_cnt and pointer are 0; array is cleared to 0.
  - Outputs busy, word_ready, data_out, data_valid and err are all 0.
  - Reset mid-operation aborts the operation: no array commit and no data_valid.
- Clocking: single clock; no other clock or reset domain.
- Shift register:
  - Shifting happens only in IDLE while shift=1. Shift is ignored in WR and RD, with no err.
  - MSB_FIRST=1: sr <= {sr[W-2:0], serial_in}. MSB_FIRST=0: sr <= {serial_in, sr[W-1:1]}.
  - bit_cnt increments per shift and saturates at DATA_WIDTH.
  - word_ready = (bit_cnt == DATA_WIDTH).
  - Shifts beyond DATA_WIDTH keep shifting; the oldest bit is dropped and word_ready stays 1.
- Effective address: ea = auto_inc ? ptr : addr.
  - On every accepted command, ptr <= ea + 1, modulo 2**ADDR_WIDTH (wraps from max to 0).
- FSM states: IDLE, WR, RD.
- IDLE, evaluated at each edge:
  - w_en & r_en both 1: err pulse, no operation, no pointer update.
  - w_en & !word_ready: err pulse, no operation.
  - w_en & word_ready: latch ea and sr; clear bit_cnt; go to WR.
  - r_en: latch ea; go to RD.
  - shift, evaluated with w_en in the same cycle: the bit is not shifted, because the command takes priority.
- WR:
  - busy=1 for exactly WRITE_CYCLES cycles after the accepting edge.
  - At edge WRITE_CYCLES after acceptance: mem[addr_q] <= wdata_q, then return to IDLE.
- RD:
  - busy=1 for exactly SENSE_CYCLES cycles.
  - At edge SENSE_CYCLES after acceptance: data_out <= mem[addr_q], data_valid=1 for one cycle, return to IDLE.
- Command while busy (w_en or r_en in WR/RD): ignored, err pulse, FSM unaffected.
- A new command is accepted on the first edge where the FSM is back in IDLE (busy=0).
- Back-to-back: read-after-write to the same address returns the new data.

Test Plan:
1. DATA_WIDTH=8, ADDR_WIDTH=4, MSB_FIRST=1, WRITE_CYCLES=1, SENSE_CYCLES=2, auto_inc=0. Shift bits 1,0,1,0,0,1,0,1, then w_en with addr=3; next r_en with addr=3 -> busy high 2 cycles, data_valid pulse 2 edges after acceptance, data_out=0xA5.
2. After test 1, shift 5 bits then pulse w_en addr=3 -> err pulse, word_ready=0, busy stays 0; read addr 3 still returns 0xA5.
3. Burst: write 0x11 with auto_inc=0, addr=14; then write 0x22 and 0x33 with auto_inc=1 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33 (pointer wraps); auto_inc reads from a pointer reloaded via addr=14 return 0x11, 0x22, 0x33.
4. w_en=r_en=1 in IDLE -> err pulse, no busy, pointer unchanged. r_en asserted during the second RD cycle -> err pulse, original read completes with correct data and only one data_valid.
5. Assert rst during the first RD cycle -> no data_valid; next cycle data_out=0, busy=0, word_ready=0; read of any address returns 0x00.
6. MSB_FIRST=0 instance: shift 1,1,1,1,0,0,0,0, write and read addr 0 -> data_out=0x0F; the MSB_FIRST=1 instance with the same sequence -> 0xF0.
